board_clock_reset_conditioner: RTL



---
 rtl/board_clock_reset_conditioner_button_debouncer.sv | 76 +++++++
 rtl/board_clock_reset_conditioner.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/board_clock_reset_conditioner_button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Debounces one raw asynchronous, active-high pushbutton.
//   1. A two-flop synchronizer brings the raw level into the clock domain.
//   2. A stability counter accepts a new level only after it has been stable
//      for DEBOUNCE_CYCLES consecutive cycles.
//
// Ports:
//   clock     in   clock
//   reset     in   asynchronous active-high reset; clears all state to 0
//   raw       in   raw button level (asynchronous)
//   debounced out  accepted level
//   pressed   out  one-cycle pulse in the cycle debounced first reads 1
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic debounced,
    output logic pressed
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_debouncer: DEBOUNCE_CYCLES must be >= 1");
    end

    logic          meta_q;
    logic          sync_q;
    logic          db_q;
    logic          db_d;
    logic          pressed_q;
    logic          pressed_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level, so any bounce back to the accepted level restarts it.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_q != db_q) begin
            if (cnt_q == C_MAX) begin
                db_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // Registered alongside db_q so the pulse lines up with the first 1.
        pressed_d = db_d & ~db_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            db_q      <= 1'b0;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            meta_q    <= raw;
            sync_q    <= meta_q;
            db_q      <= db_d;
            pressed_q <= pressed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign debounced = db_q;
    assign pressed   = pressed_q;

endmodule

// File: rtl/board_clock_reset_conditioner.sv
// -----------------------------------------------------------------------------
// board_clock_reset_conditioner
// Board-level front end: divides the board clock, debounces the reset button
// and general buttons, and sequences a stretched active-low system reset whose
// release is aligned to the falling edge of the divided clock.
//
// Ports:
//   clock             in   board clock
//   reset             in   asynchronous active-high power-on/external reset
//   reset_button      in   raw reset pushbutton, active-high
//   buttons           in   raw general buttons, active-high
//   clock_divided     out  clock / CLOCK_DIVIDER, 50 % duty, registered
//   clock_enable      out  strobe in the last low-phase cycle of clock_divided
//   reset_n_out       out  active-low system reset
//   buttons_debounced out  debounced button levels
//   buttons_pressed   out  one-cycle pulse per debounced 0->1
// -----------------------------------------------------------------------------
module board_clock_reset_conditioner #(
    parameter int CLOCK_DIVIDER     = 2,
    parameter int NUM_BUTTONS       = 1,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int RESET_HOLD_CYCLES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   reset_button,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic                   clock_divided,
    output logic                   clock_enable,
    output logic                   reset_n_out,
    output logic [NUM_BUTTONS-1:0] buttons_debounced,
    output logic [NUM_BUTTONS-1:0] buttons_pressed
);

    localparam int PW = (CLOCK_DIVIDER > 2) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(CLOCK_DIVIDER - 1);
    localparam logic [PW-1:0] P_HIGH = PW'(CLOCK_DIVIDER / 2);
    localparam logic [PW-1:0] P_EN   = PW'(CLOCK_DIVIDER / 2 - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(RESET_HOLD_CYCLES - 1);

    if (CLOCK_DIVIDER < 2 || (CLOCK_DIVIDER % 2) != 0) begin : g_bad_divider
        $fatal(1, "CLOCK_DIVIDER must be even and >= 2");
    end
    if (NUM_BUTTONS < 1) begin : g_bad_buttons
        $error("NUM_BUTTONS must be >= 1");
    end
    if (RESET_HOLD_CYCLES < 1) begin : g_bad_hold
        $error("RESET_HOLD_CYCLES must be >= 1");
    end

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // ------------------------------------------------------------------ divider
    logic [PW-1:0] p_q;
    logic [PW-1:0] p_d;
    logic          clk_div_q;
    logic          clk_div_d;
    logic          clk_en_q;
    logic          clk_en_d;

    // Outputs are decoded from the next phase so the registered values track
    // the current phase exactly.
    always_comb begin
        p_d       = (p_q == P_LAST) ? '0 : p_q + PW'(1);
        clk_div_d = (p_d >= P_HIGH);
        clk_en_d  = (p_d == P_EN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_q       <= '0;
            clk_div_q <= 1'b0;
            clk_en_q  <= 1'b0;
        end else begin
            p_q       <= p_d;
            clk_div_q <= clk_div_d;
            clk_en_q  <= clk_en_d;
        end
    end

    assign clock_divided = clk_div_q;
    assign clock_enable  = clk_en_q;

    // ---------------------------------------------------------------- debounce
    // Channel NUM_BUTTONS is the reset button; the rest map to buttons[].
    logic [NUM_BUTTONS:0] raw_all;
    logic [NUM_BUTTONS:0] db_all;
    logic [NUM_BUTTONS:0] pr_all;

    assign raw_all = {reset_button, buttons};

    genvar gi;
    for (gi = 0; gi <= NUM_BUTTONS; gi++) begin : g_debounce
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clock    (clock),
            .reset    (reset),
            .raw      (raw_all[gi]),
            .debounced(db_all[gi]),
            .pressed  (pr_all[gi])
        );
    end

    assign buttons_debounced = db_all[NUM_BUTTONS-1:0];
    assign buttons_pressed   = pr_all[NUM_BUTTONS-1:0];

    logic rst_btn_level;
    logic rst_btn_rise;
    assign rst_btn_level = db_all[NUM_BUTTONS];
    assign rst_btn_rise  = pr_all[NUM_BUTTONS];

    // --------------------------------------------------------------- sequencer
    seq_state_t    state_q;
    seq_state_t    state_d;
    logic [HW-1:0] h_q;
    logic [HW-1:0] h_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= HOLD;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        case (state_q)
            HOLD: begin
                if (rst_btn_level) begin
                    h_d = '0;
                end else if (h_q != H_MAX) begin
                    h_d = h_q + HW'(1);
                end
                // Leaving on the last phase makes reset_n_out rise together
                // with the falling edge of clock_divided.
                if (h_q == H_MAX && !rst_btn_level && p_q == P_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                h_d = '0;
                // RUN is only entered with the debounced level at 0, so its
                // rising pulse marks the first cycle it reads 1.
                if (rst_btn_rise) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = HOLD;
                h_d     = '0;
            end
        endcase
    end

    always_comb begin
        reset_n_out = (state_q == RUN);
    end

endmodule
